// File: rtl/phy_tx_lane_serializer_if.sv
// Byte-stream handshake into the lane serializer: a byte moves on valid_in && ready_out.
interface phy_tx_lane_serializer_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;

   modport master (output data_in, output valid_in, input ready_out);
   modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/phy_tx_lane_serializer.sv
// Lane TX serializer: FIFO bytes out MSB first, 8 clk/byte, COMMA preamble then data/IDLE; latency 1..8 clk, ready_out low when FIFO full.
// Optional PHY_TX_RESYNC_EN adds i_resync_req, which re-sends the comma preamble at the next byte boundary.
module phy_tx_lane_serializer #(
   parameter int         DEPTH       = 4,
   parameter int         COMMA_COUNT = 4,
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter logic [7:0] IDLE        = 8'h7C
) (
   input  logic i_clk_32f,
   input  logic i_reset_L,
`ifdef PHY_TX_RESYNC_EN
   input  logic i_resync_req,
`endif
   phy_tx_lane_serializer_if.slave i_byte_if,
   output logic o_data_out,
   output logic o_byte_start,
   output logic o_active
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int CCW = $clog2(COMMA_COUNT + 1);

   typedef enum logic {SYNC, RUN} state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [7:0]     r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  w_count_nxt;
   logic           r_ready;
   logic [2:0]     r_bit_cnt;
   logic [CCW-1:0] r_comma_cnt;
   logic [CCW-1:0] w_comma_nxt;
   logic [CCW-1:0] w_comma_base;
   logic [CCW-1:0] w_comma_inc;
   logic [6:0]     r_shreg;
   logic           r_data_out;
   logic           r_byte_start;
   logic           r_active;
   logic           w_active_nxt;
   logic [7:0]     w_byte;
   logic           w_pop;
   logic           w_push;
   logic           w_boundary;
   logic           w_resync;

`ifdef PHY_TX_RESYNC_EN
   logic r_resync_pend;

   // A request landing on the boundary edge itself acts on that same slot.
   assign w_resync = r_resync_pend | i_resync_req;

   always_ff @(posedge i_clk_32f or negedge i_reset_L) begin
      if (!i_reset_L)     r_resync_pend <= 1'b0;
      else if (w_boundary) r_resync_pend <= 1'b0;
      else if (i_resync_req) r_resync_pend <= 1'b1;
   end
`else
   assign w_resync = 1'b0;
`endif

   assign w_boundary   = (r_bit_cnt == 3'd0);
   assign w_push       = i_byte_if.valid_in && r_ready;
   assign w_comma_base = w_resync ? '0 : r_comma_cnt;
   assign w_comma_inc  = w_comma_base + CCW'(1);

   always_ff @(posedge i_clk_32f or negedge i_reset_L) begin
      if (!i_reset_L) r_state <= SYNC;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_comma_nxt  = r_comma_cnt;
      w_active_nxt = r_active;
      w_byte       = IDLE;
      w_pop        = 1'b0;
      if (w_boundary) begin
         if (r_state == SYNC || w_resync) begin
            w_byte       = COMMA;
            w_comma_nxt  = w_comma_inc;
            w_active_nxt = 1'b0;
            w_state_nxt  = (w_comma_inc == CCW'(COMMA_COUNT)) ? RUN : SYNC;
         end else begin
            w_active_nxt = 1'b1;
            if (r_count != '0) begin
               w_byte = r_mem[r_rd_ptr];
               w_pop  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_clk_32f) begin
      if (w_push) r_mem[r_wr_ptr] <= i_byte_if.data_in;
   end

   always_ff @(posedge i_clk_32f or negedge i_reset_L) begin
      if (!i_reset_L) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_ready      <= 1'b0;
         r_bit_cnt    <= 3'd0;
         r_comma_cnt  <= '0;
         r_shreg      <= 7'd0;
         r_data_out   <= 1'b0;
         r_byte_start <= 1'b0;
         r_active     <= 1'b0;
      end else begin
         r_bit_cnt    <= r_bit_cnt + 3'd1;
         r_comma_cnt  <= w_comma_nxt;
         r_active     <= w_active_nxt;
         r_byte_start <= w_boundary;
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         // Registered from the post-edge count, so a pop into a full FIFO frees a slot one cycle later.
         r_ready <= (w_count_nxt < CW'(DEPTH));
         if (w_boundary) begin
            r_data_out <= w_byte[7];
            r_shreg    <= w_byte[6:0];
         end else begin
            r_data_out <= r_shreg[6];
            r_shreg    <= {r_shreg[5:0], 1'b0};
         end
      end
   end

   assign i_byte_if.ready_out = r_ready;
   assign o_data_out          = r_data_out;
   assign o_byte_start        = r_byte_start;
   assign o_active            = r_active;
endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Directed bench for phy_tx_lane_serializer: samples on the falling edge, rebuilds bytes from the serial stream.
module tb_phy_tx_lane_serializer;
   logic clk_32f = 1'b0;
   logic reset_L = 1'b1;
`ifdef PHY_TX_RESYNC_EN
   logic resync_req = 1'b0;
`endif
   logic data_out;
   logic byte_start;
   logic active;

   phy_tx_lane_serializer_if byte_if ();

   phy_tx_lane_serializer dut (
      .i_clk_32f    (clk_32f),
      .i_reset_L    (reset_L),
`ifdef PHY_TX_RESYNC_EN
      .i_resync_req (resync_req),
`endif
      .i_byte_if    (byte_if),
      .o_data_out   (data_out),
      .o_byte_start (byte_start),
      .o_active     (active)
   );

   always #5 clk_32f = ~clk_32f;

   int         n_checks;
   int         n_fail;
   int         cyc;
   int         nb;
   int         last_start;
   int         bad_gap;
   int         accepted;
   int         acc_at_low;
   bit         low_seen;
   bit         drove_valid;
   logic       drove_ready;
   logic [7:0] cur;
   logic [7:0] rx_q [$];
   logic [7:0] push_q [$];
   logic       act_hist [256];
   logic       rdy_hist [256];
   logic [7:0] t3_dat [6] = '{8'h01, 8'h80, 8'hFF, 8'h5A, 8'hC3, 8'h7E};

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rx(input string tag, input int idx, input logic [7:0] exp);
      logic [7:0] v;
      v = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
      n_checks++;
      assert (v === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, v, exp);
      end
   endtask

   task automatic drive();
      if (push_q.size() != 0) begin
         byte_if.valid_in = 1'b1;
         byte_if.data_in  = push_q[0];
         drove_valid      = 1'b1;
      end else begin
         byte_if.valid_in = 1'b0;
         drove_valid      = 1'b0;
      end
      drove_ready = byte_if.ready_out;
   endtask

   task automatic step();
      @(negedge clk_32f);
      if (drove_valid && drove_ready === 1'b1) begin
         push_q.delete(0);
         accepted++;
      end
      if (!low_seen && accepted > 0 && byte_if.ready_out === 1'b0) begin
         low_seen   = 1'b1;
         acc_at_low = accepted;
      end
      if (cyc < 256) begin
         act_hist[cyc] = active;
         rdy_hist[cyc] = byte_if.ready_out;
      end
      if (byte_start === 1'b1) begin
         if (last_start >= 0 && cyc - last_start != 8) bad_gap++;
         last_start = cyc;
         cur = {7'd0, data_out};
         nb  = 1;
      end else if (nb != 0) begin
         cur = {cur[6:0], data_out};
         nb++;
      end
      if (nb == 8) begin
         rx_q.push_back(cur);
         nb = 0;
      end
      cyc++;
      drive();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset_L          = 1'b0;
      byte_if.valid_in = 1'b0;
      #1;
      chk1("rst_data_out", data_out, 1'b0);
      chk1("rst_byte_start", byte_start, 1'b0);
      chk1("rst_active", active, 1'b0);
      chk1("rst_ready_out", byte_if.ready_out, 1'b0);
      @(negedge clk_32f);
      reset_L = 1'b1;
      rx_q.delete();
      push_q.delete();
      cur         = 8'd0;
      nb          = 0;
      cyc         = 0;
      last_start  = -1;
      bad_gap     = 0;
      accepted    = 0;
      acc_at_low  = 0;
      low_seen    = 1'b0;
      drove_valid = 1'b0;
      drove_ready = 1'b0;
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      byte_if.valid_in = 1'b0;
      byte_if.data_in  = 8'd0;
      @(negedge clk_32f);

      // T1: idle lane after reset
      do_reset();
      run(48);
      chk1("t1_ready_after_release", rdy_hist[0], 1'b1);
      chki("t1_byte_count", rx_q.size(), 6);
      for (int i = 0; i < 4; i++) chk_rx("t1_comma", i, 8'hBC);
      chk_rx("t1_idle", 4, 8'h7C);
      chk_rx("t1_idle", 5, 8'h7C);
      chk1("t1_active_bit31", act_hist[31], 1'b0);
      chk1("t1_active_bit32", act_hist[32], 1'b1);
      chki("t1_bad_gaps", bad_gap, 0);

      // T2: byte pushed during the comma preamble
      do_reset();
      run(1);
      push_q.push_back(8'hA5);
      drive();
      run(47);
      chki("t2_byte_count", rx_q.size(), 6);
      for (int i = 0; i < 4; i++) chk_rx("t2_comma", i, 8'hBC);
      chk_rx("t2_data", 4, 8'hA5);
      chk_rx("t2_idle", 5, 8'h7C);
      chki("t2_bad_gaps", bad_gap, 0);

      // T3: six back-to-back bytes in RUN against a 4-deep FIFO
      do_reset();
      run(34);
      for (int i = 0; i < 6; i++) push_q.push_back(t3_dat[i]);
      drive();
      run(62);
      chki("t3_accepted_at_ready_low", acc_at_low, 4);
      chki("t3_accepted_total", accepted, 6);
      chki("t3_byte_count", rx_q.size(), 12);
      chk_rx("t3_idle_before", 4, 8'h7C);
      for (int i = 0; i < 6; i++) chk_rx("t3_data", 5 + i, t3_dat[i]);
      chk_rx("t3_idle_after", 11, 8'h7C);
      chki("t3_bad_gaps", bad_gap, 0);

      // T4: reset while bit 3 of a data byte is on the line, FIFO still holding a byte
      do_reset();
      run(34);
      push_q.push_back(8'h08);
      push_q.push_back(8'h55);
      drive();
      run(11);
      chk1("t4_bit3_before_reset", data_out, 1'b1);
      chk1("t4_active_before_reset", active, 1'b1);
      do_reset();
      run(48);
      chki("t4_byte_count", rx_q.size(), 6);
      for (int i = 0; i < 4; i++) chk_rx("t4_comma", i, 8'hBC);
      chk_rx("t4_idle_fifo_flushed", 4, 8'h7C);
      chk_rx("t4_idle_fifo_flushed", 5, 8'h7C);

      // T5: push on the exact boundary edge with the FIFO empty
      do_reset();
      run(40);
      push_q.push_back(8'h3C);
      drive();
      run(24);
      chki("t5_byte_count", rx_q.size(), 8);
      chk_rx("t5_idle_on_push_slot", 5, 8'h7C);
      chk_rx("t5_data_next_slot", 6, 8'h3C);
      chk_rx("t5_idle_after", 7, 8'h7C);

`ifdef PHY_TX_RESYNC_EN
      // T6: one-cycle resync request in the middle of a data byte
      do_reset();
      run(34);
      push_q.push_back(8'h11);
      push_q.push_back(8'h22);
      push_q.push_back(8'h33);
      drive();
      run(9);
      resync_req = 1'b1;
      run(1);
      resync_req = 1'b0;
      run(60);
      chki("t6_byte_count", rx_q.size(), 13);
      chk_rx("t6_data_in_flight", 5, 8'h11);
      for (int i = 6; i < 10; i++) chk_rx("t6_recomma", i, 8'hBC);
      chk_rx("t6_data_after", 10, 8'h22);
      chk_rx("t6_data_after", 11, 8'h33);
      chk_rx("t6_idle_after", 12, 8'h7C);
      chk1("t6_active_bit47", act_hist[47], 1'b1);
      chk1("t6_active_bit48", act_hist[48], 1'b0);
      chk1("t6_active_bit79", act_hist[79], 1'b0);
      chk1("t6_active_bit80", act_hist[80], 1'b1);
      chki("t6_bad_gaps", bad_gap, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
